// File: rtl/fc_mac_seq_if.sv
// Bus bundle for the fully-connected MAC sequencer: job control, the paired
// src_buf/weight read port, and the dst_buf write port.
interface fc_mac_seq_if #(
  parameter int IA_W = 11,
  parameter int OA_W = 12,
  parameter int WA_W = 23
);
  logic            start;
  logic [IA_W-1:0] len;
  logic [OA_W-1:0] num_o;
  logic            exec;
  logic [IA_W-1:0] ia;
  logic [WA_W-1:0] wa;
  logic [31:0]     d;
  logic [31:0]     w;
  logic            outr;
  logic [OA_W-1:0] oa;
  logic [31:0]     result;
  logic            busy;
  logic            done;

  // The sequencer owns the memory ports and status.
  modport master (
    input  start, len, num_o, d, w,
    output exec, ia, wa, outr, oa, result, busy, done
  );

  // The surrounding system launches jobs and returns memory data.
  modport slave (
    output start, len, num_o, d, w,
    input  exec, ia, wa, outr, oa, result, busy, done
  );
endinterface

// File: rtl/fc_mac_seq.sv
// Matrix-vector sequencer/MAC. Streams one (d, w) pair per cycle from the
// source buffer and weight memory, accumulates Q16.16 products, and writes
// one result per output neuron into the destination buffer.
module fc_mac_seq #(
  parameter int IA_W = 11,
  parameter int OA_W = 12,
  parameter int WA_W = 23
) (
  input  logic            clk,
  input  logic            rst_n,
  fc_mac_seq_if.master    bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state;
  logic [IA_W-1:0] n_last;   // len-1, latched at start
  logic [OA_W-1:0] m_last;   // num_o-1, latched at start
  logic [OA_W-1:0] o_cnt;    // output neuron currently being issued

  // Pipeline stage 1: tags aligned with returning d/w.
  logic            s1_v, s1_first, s1_last;
  logic [OA_W-1:0] s1_o;
  // Pipeline stage 2: tags aligned with the registered product.
  logic            s2_v, s2_first, s2_last;
  logic [OA_W-1:0] s2_o;
  logic [31:0]     p;
  logic [31:0]     acc;

  // Sign-extend to 48 bits: bits above 47 are never used after the >>>16
  // and 32-bit truncation, so a 48-bit product is exact where it matters.
  logic signed [47:0] d_ext, w_ext, prod;
  assign d_ext = {{16{bus.d[31]}}, bus.d};
  assign w_ext = {{16{bus.w[31]}}, bus.w};
  assign prod  = d_ext * w_ext;

  // The accumulator is the write data; outr only strobes once it is final.
  assign bus.result = acc;

  // Job sequencer: issues one read per cycle and tracks job completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bus.exec <= 1'b0;
      bus.ia   <= '0;
      bus.wa   <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      n_last   <= '0;
      m_last   <= '0;
      o_cnt    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch
      // sees the pre-edge values, independent of statement order.
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            if (bus.len != '0 && bus.num_o != '0) begin
              state    <= RUN;
              bus.exec <= 1'b1;
              bus.ia   <= '0;
              bus.wa   <= '0;
              o_cnt    <= '0;
              n_last   <= bus.len - 1'b1;
              m_last   <= bus.num_o - 1'b1;
            end else begin
              // Empty job: complete immediately without touching memory.
              state    <= DONE;
              bus.done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.ia == n_last) begin
            bus.ia <= '0;
            if (o_cnt == m_last) begin
              bus.exec <= 1'b0;
              state    <= DRAIN;
            end else begin
              o_cnt  <= o_cnt + 1'b1;
              bus.wa <= bus.wa + 1'b1;
            end
          end else begin
            bus.ia <= bus.ia + 1'b1;
            bus.wa <= bus.wa + 1'b1;
          end
        end
        DRAIN: begin
          // The final write is on the bus this cycle; done follows it.
          if (bus.outr && bus.oa == m_last) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // MAC pipeline: tag alignment, product register, accumulate and write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v     <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_o     <= '0;
      s2_v     <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_o     <= '0;
      p        <= '0;
      acc      <= '0;
      bus.outr <= 1'b0;
      bus.oa   <= '0;
    end else begin
      s1_v     <= bus.exec;
      s1_first <= (bus.ia == '0);
      s1_last  <= (bus.ia == n_last);
      s1_o     <= o_cnt;

      s2_v     <= s1_v;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_o     <= s1_o;
      p        <= 32'(prod >>> 16);

      // First term of each output overwrites, so no clear cycle is needed.
      if (s2_v) acc <= s2_first ? p : acc + p;
      bus.outr <= s2_v && s2_last;
      if (s2_v && s2_last) bus.oa <= s2_o;
    end
  end

endmodule
